// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - beat input, group config and result handshake bundle for psum_accumulator.
interface psum_accumulator_if #(
  parameter int IN_W  = 6,
  parameter int ACC_W = 10,
  parameter int CNT_W = 4
);
  logic [CNT_W-1:0] cfg_len;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates cfg_len adder beats into a wider total with overflow flag.
// Define PSUM_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module psum_accumulator #(
  parameter int IN_W  = 6,
  parameter int ACC_W = 10,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  psum_accumulator_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_len;
  logic             r_ovf;
  logic             r_in_ready;

  logic             w_accept;
  logic [CNT_W-1:0] w_first_len;
  logic [CNT_W-1:0] w_count_inc;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_nxt;

  assign w_accept    = bus.in_valid & r_in_ready;
  assign w_first_len = (bus.cfg_len == '0) ? CNT_W'(1) : bus.cfg_len;
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_sum       = {1'b0, r_acc} + (ACC_W+1)'(bus.in_data);
  assign w_carry     = w_sum[ACC_W];

`ifdef PSUM_ACC_SATURATE_EN
  // Once clamped, the total stays pinned at full scale until the group ends
  assign w_acc_nxt = (w_carry | r_ovf) ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_first_len == CNT_W'(1)) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept && (w_count_inc == r_len)) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_HOLD);
      if (w_accept) begin
        if (r_state == S_IDLE) begin
          r_acc   <= ACC_W'(bus.in_data);
          r_count <= CNT_W'(1);
          r_len   <= w_first_len;
          r_ovf   <= 1'b0;
        end else begin
          r_acc   <= w_acc_nxt;
          r_count <= w_count_inc;
          r_ovf   <= r_ovf | w_carry;
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out_data  = r_acc;
  assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed bench driving a 10-bit and a 9-bit accumulator against a true-sum model.
module tb_psum_accumulator;
  logic       clk;
  logic       rst;
  logic [3:0] cfg_len;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_ready;

  psum_accumulator_if #(.IN_W(6), .ACC_W(10), .CNT_W(4)) bus10 ();
  psum_accumulator_if #(.IN_W(6), .ACC_W(9),  .CNT_W(4)) bus9 ();

  assign bus10.cfg_len   = cfg_len;
  assign bus10.in_valid  = in_valid;
  assign bus10.in_data   = in_data;
  assign bus10.out_ready = out_ready;
  assign bus9.cfg_len    = cfg_len;
  assign bus9.in_valid   = in_valid;
  assign bus9.in_data    = in_data;
  assign bus9.out_ready  = out_ready;

  psum_accumulator #(.IN_W(6), .ACC_W(10), .CNT_W(4)) dut10 (.clk(clk), .rst(rst), .bus(bus10));
  psum_accumulator #(.IN_W(6), .ACC_W(9),  .CNT_W(4)) dut9  (.clk(clk), .rst(rst), .bus(bus9));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 idle, 1 collecting, 2 holding; the group total is kept as an exact integer
  int m_phase = 0;
  int m_cnt   = 0;
  int m_len   = 1;
  int m_sum   = 0;
  bit m_ready = 1'b0;
  bit m_valid = 1'b0;

  function automatic int exp_data(int sum, int w);
    int lim;
    lim = (1 << w) - 1;
`ifdef PSUM_ACC_SATURATE_EN
    return (sum > lim) ? lim : sum;
`else
    return sum % (1 << w);
`endif
  endfunction

  function automatic int exp_ovf(int sum, int w);
    return (sum > ((1 << w) - 1)) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_sum   = 0;
      m_ready = 1'b0;
      m_valid = 1'b0;
    end else begin
      acc = in_valid && m_ready;
      case (m_phase)
        0: if (acc) begin
          m_len   = (cfg_len == 0) ? 1 : int'(cfg_len);
          m_cnt   = 1;
          m_sum   = int'(in_data);
          m_phase = (m_cnt == m_len) ? 2 : 1;
        end
        1: if (acc) begin
          m_cnt++;
          m_sum += int'(in_data);
          if (m_cnt == m_len) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
      m_valid = (m_phase == 2);
      m_ready = (m_phase != 2);
    end
  endtask

  // One clock: advance the model on the inputs about to be sampled, then compare at the falling edge
  task automatic cyc();
    model_step();
    @(negedge clk);
    chk("in_ready10", int'(bus10.in_ready), int'(m_ready));
    chk("out_valid10", int'(bus10.out_valid), int'(m_valid));
    chk("in_ready9", int'(bus9.in_ready), int'(m_ready));
    chk("out_valid9", int'(bus9.out_valid), int'(m_valid));
    if (m_valid) begin
      chk("out_data10", int'(bus10.out_data), exp_data(m_sum, 10));
      chk("out_ovf10", int'(bus10.out_ovf), exp_ovf(m_sum, 10));
      chk("out_data9", int'(bus9.out_data), exp_data(m_sum, 9));
      chk("out_ovf9", int'(bus9.out_ovf), exp_ovf(m_sum, 9));
    end
  endtask

  task automatic beat(input int d);
    in_valid = 1'b1;
    in_data  = 6'(d);
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat9;
`ifdef PSUM_ACC_SATURATE_EN
    sat9 = 511;
`else
    sat9 = 433;
`endif
    rst       = 1'b1;
    cfg_len   = 4'd0;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b1;
    idle();
    idle();
    chk("rst_out_valid", int'(bus10.out_valid), 0);
    chk("rst_in_ready", int'(bus10.in_ready), 0);
    chk("rst_out_data", int'(bus10.out_data), 0);
    chk("rst_out_ovf", int'(bus10.out_ovf), 0);
    rst = 1'b0;
    idle();
    chk("post_rst_in_ready", int'(bus10.in_ready), 1);

    // Basic group of four
    cfg_len = 4'd4;
    beat(5); beat(10); beat(20); beat(63);
    chk("basic_valid", int'(bus10.out_valid), 1);
    chk("basic_data", int'(bus10.out_data), 98);
    chk("basic_ovf", int'(bus10.out_ovf), 0);
    chk("basic_model", exp_data(m_sum, 10), 98);
    idle();
    chk("basic_done_valid", int'(bus10.out_valid), 0);
    chk("basic_done_ready", int'(bus10.in_ready), 1);

    // Backpressure with ignored beats during hold
    cfg_len   = 4'd2;
    out_ready = 1'b0;
    beat(7); beat(9);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 6'd50;
      cyc();
      chk("bp_ready", int'(bus10.in_ready), 0);
      chk("bp_valid", int'(bus10.out_valid), 1);
      chk("bp_data", int'(bus10.out_data), 16);
    end
    out_ready = 1'b1;
    idle();
    chk("bp_release", int'(bus10.out_valid), 0);

    // Zero length acts as one beat
    cfg_len = 4'd0;
    beat(33);
    chk("len0_valid", int'(bus10.out_valid), 1);
    chk("len0_data", int'(bus10.out_data), 33);
    idle();

    // Bubbles between beats
    cfg_len = 4'd3;
    beat(1); idle(); beat(2); idle(); idle(); beat(3);
    chk("bubble_data", int'(bus10.out_data), 6);
    chk("bubble_valid", int'(bus10.out_valid), 1);
    idle();

    // Longest group at full-scale input
    cfg_len = 4'd15;
    for (int i = 0; i < 15; i++) beat(63);
    chk("long_data10", int'(bus10.out_data), 945);
    chk("long_ovf10", int'(bus10.out_ovf), 0);
    chk("long_data9", int'(bus9.out_data), sat9);
    chk("long_ovf9", int'(bus9.out_ovf), 1);
    chk("long_model9", exp_data(m_sum, 9), sat9);
    idle();

    // Reset in mid-group discards the partial total
    cfg_len = 4'd4;
    beat(1); beat(1);
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("midrst_valid", int'(bus10.out_valid), 0);
    chk("midrst_ready", int'(bus10.in_ready), 0);
    rst = 1'b0;
    idle();
    beat(1); beat(1); beat(1); beat(1);
    chk("midrst_data", int'(bus10.out_data), 4);
    chk("midrst_ovf", int'(bus10.out_ovf), 0);
    idle();

    // Length change inside a group is ignored
    cfg_len = 4'd3;
    beat(2);
    cfg_len = 4'd8;
    beat(3); beat(4);
    chk("cfgchg_valid", int'(bus10.out_valid), 1);
    chk("cfgchg_data", int'(bus10.out_data), 9);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
